data_sram_responder: RTL and testbench

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder.sv | 119 +++++++++++
 tb/tb_data_sram_responder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Single-port data SRAM with a small peripheral window (LED, free-running timer,
// RAM-write counter). One access per cycle, registered read data, sticky error flag.
module data_sram_responder #(
   parameter int          MEM_AW    = 10,
   parameter logic [15:0] PERI_BASE = 16'hbfaf
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic [31:0] timer,
   output logic        err
);

   localparam logic [15:0] OFF_LED    = 16'hf000;
   localparam logic [15:0] OFF_TIMER  = 16'he000;
   localparam logic [15:0] OFF_WCOUNT = 16'hf020;

   logic [31:0]       r_mem [2**MEM_AW];
   logic [31:0]       r_rdata;
   logic [15:0]       r_led;
   logic [31:0]       r_timer;
   logic [31:0]       r_wcount;
   logic              r_err;

   logic              w_peri;
   logic [15:0]       w_off;
   logic [MEM_AW-1:0] w_idx;
   logic              w_sel_led;
   logic              w_sel_timer;
   logic              w_sel_wcount;
   logic              w_unmapped;
   logic              w_misalign;
   logic              w_ram_we;
   logic [31:0]       w_peri_rd;

   // Byte-offset low bits are ignored for decode, so misaligned accesses hit the word.
   assign w_peri       = (data_sram_addr[31:16] == PERI_BASE);
   assign w_off        = {data_sram_addr[15:2], 2'b00};
   assign w_idx        = data_sram_addr[MEM_AW+1:2];
   assign w_sel_led    = w_peri && (w_off == OFF_LED);
   assign w_sel_timer  = w_peri && (w_off == OFF_TIMER);
   assign w_sel_wcount = w_peri && (w_off == OFF_WCOUNT);
   assign w_unmapped   = w_peri && !(w_sel_led || w_sel_timer || w_sel_wcount);
   assign w_misalign   = |data_sram_addr[1:0];
   assign w_ram_we     = data_sram_we && !w_peri && !reset;

   always_comb begin
      w_peri_rd = 32'h0;
      if (w_sel_led)
         w_peri_rd = {16'h0, r_led};
      else if (w_sel_timer)
         w_peri_rd = r_timer;
      else if (w_sel_wcount)
         w_peri_rd = r_wcount;
   end

   // RAM has no reset; writes are gated off while reset is held.
   always_ff @(posedge clk) begin
      if (w_ram_we)
         r_mem[w_idx] <= data_sram_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= 32'h0;
      end else if (w_peri) begin
         r_rdata <= w_peri_rd;
      end else begin
         r_rdata <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led <= 16'h0;
      end else if (data_sram_we && w_sel_led) begin
         r_led <= data_sram_wdata[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= 32'h0;
      end else if (data_sram_we && w_sel_timer) begin
         r_timer <= data_sram_wdata;
      end else begin
         r_timer <= r_timer + 32'd1;
      end
   end

   // Clear wins over increment; the counter saturates instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wcount <= 32'h0;
      end else if (data_sram_we && w_sel_wcount) begin
         r_wcount <= 32'h0;
      end else if (w_ram_we && (r_wcount != 32'hffff_ffff)) begin
         r_wcount <= r_wcount + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_unmapped || w_misalign) begin
         r_err <= 1'b1;
      end
   end

   assign data_sram_rdata = r_rdata;
   assign led             = r_led;
   assign timer           = r_timer;
   assign err             = r_err;

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: directed scenarios plus a randomized run,
// all checked against an abstract reference model of memory and peripherals.
module tb_data_sram_responder;

   localparam int          MEM_AW    = 10;
   localparam logic [15:0] PERI_BASE = 16'hbfaf;

   logic        clk;
   logic        reset;
   logic        data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [31:0] timer;
   logic        err;

   int n_checks;
   int n_errors;

   logic [31:0] m_mem [int];
   logic [15:0] m_led;
   logic [31:0] m_timer;
   logic [31:0] m_wcount;
   logic        m_err;
   logic [31:0] exp_rdata;
   logic        exp_known;

   data_sram_responder #(.MEM_AW(MEM_AW), .PERI_BASE(PERI_BASE)) dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .timer           (timer),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_led     = 16'h0;
      m_timer   = 32'h0;
      m_wcount  = 32'h0;
      m_err     = 1'b0;
      exp_rdata = 32'h0;
      exp_known = 1'b1;
   endtask

   // One clock edge of behaviour: read sees pre-edge state, then state updates.
   task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
      bit          peri;
      int unsigned word_off;
      int          idx;
      peri     = (a[31:16] == PERI_BASE);
      word_off = (int'(a[15:0]) / 4) * 4;
      idx      = int'((a / 4) % (32'd1 << MEM_AW));
      exp_known = 1'b1;
      if (peri) begin
         if (word_off == 'hf000)      exp_rdata = {16'h0, m_led};
         else if (word_off == 'he000) exp_rdata = m_timer;
         else if (word_off == 'hf020) exp_rdata = m_wcount;
         else begin
            exp_rdata = 32'h0;
            m_err     = 1'b1;
         end
      end else if (m_mem.exists(idx)) begin
         exp_rdata = m_mem[idx];
      end else begin
         exp_known = 1'b0;
      end
      if (a % 4 != 0) m_err = 1'b1;
      if (peri && we && word_off == 'he000) m_timer = d;
      else m_timer = m_timer + 32'd1;
      if (peri && we && word_off == 'hf000) m_led = d[15:0];
      if (peri && we && word_off == 'hf020) m_wcount = 32'h0;
      if (!peri && we) begin
         m_mem[idx] = d;
         if (m_wcount != 32'hffff_ffff) m_wcount = m_wcount + 32'd1;
      end
   endtask

   task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
      data_sram_we    = we;
      data_sram_addr  = a;
      data_sram_wdata = d;
      model_step(we, a, d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      data_sram_we = 1'b0;
      data_sram_addr = 32'h0;
      data_sram_wdata = 32'h0;
      model_reset();
      #1;
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL reset_rdata: got %h expected 0", data_sram_rdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (led !== 16'h0) begin
         n_errors++; $display("FAIL reset_led: got %h expected 0", led);
      end
      n_checks++;
      if (timer !== 32'h0) begin
         n_errors++; $display("FAIL reset_timer: got %h expected 0", timer);
      end
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++; $display("FAIL reset_err: got %b expected 0", err);
      end
      reset = 1'b0;
      cycle(1'b0, 32'hbfaff020, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL reset_wcount: got %h expected 0", data_sram_rdata);
      end
      n_checks++;
      if (timer !== 32'h1) begin
         n_errors++; $display("FAIL reset_first_edge_timer: got %h expected 1", timer);
      end
   endtask

   task automatic test_write_read();
      cycle(1'b1, 32'h1c000010, 32'hdeadbeef);
      cycle(1'b0, 32'h1c000010, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'hdeadbeef) begin
         n_errors++; $display("FAIL write_read: got %h expected deadbeef", data_sram_rdata);
      end
      cycle(1'b0, 32'hbfaff020, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h1) begin
         n_errors++; $display("FAIL wcount_after_write: got %h expected 1", data_sram_rdata);
      end
   endtask

   task automatic test_read_before_write();
      cycle(1'b1, 32'h00000010, 32'h11);
      cycle(1'b1, 32'h00000010, 32'h22);
      n_checks++;
      if (data_sram_rdata !== 32'h11) begin
         n_errors++; $display("FAIL rbw_old: got %h expected 11", data_sram_rdata);
      end
      cycle(1'b0, 32'h00000010, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h22) begin
         n_errors++; $display("FAIL rbw_new: got %h expected 22", data_sram_rdata);
      end
   endtask

   task automatic test_timer();
      logic [31:0] pre;
      cycle(1'b1, 32'hbfafe000, 32'hfffffffe);
      n_checks++;
      if (timer !== 32'hfffffffe) begin
         n_errors++; $display("FAIL timer_load: got %h expected fffffffe", timer);
      end
      cycle(1'b0, 32'h00000010, 32'h0);
      n_checks++;
      if (timer !== 32'hffffffff) begin
         n_errors++; $display("FAIL timer_inc: got %h expected ffffffff", timer);
      end
      cycle(1'b0, 32'h00000010, 32'h0);
      n_checks++;
      if (timer !== 32'h0) begin
         n_errors++; $display("FAIL timer_wrap: got %h expected 0", timer);
      end
      pre = timer;
      cycle(1'b0, 32'hbfafe000, 32'h0);
      n_checks++;
      if (data_sram_rdata !== pre) begin
         n_errors++; $display("FAIL timer_read: got %h expected %h", data_sram_rdata, pre);
      end
   endtask

   task automatic test_led();
      cycle(1'b1, 32'hbfaff000, 32'h1234abcd);
      n_checks++;
      if (led !== 16'habcd) begin
         n_errors++; $display("FAIL led_write: got %h expected abcd", led);
      end
      cycle(1'b0, 32'hbfaff000, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h0000abcd) begin
         n_errors++; $display("FAIL led_read: got %h expected 0000abcd", data_sram_rdata);
      end
      cycle(1'b0, 32'h00000010, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h22) begin
         n_errors++; $display("FAIL peri_write_ram_isolation: got %h expected 22", data_sram_rdata);
      end
   endtask

   task automatic test_wcount_clear();
      cycle(1'b1, 32'hbfaff020, 32'h5555);
      cycle(1'b0, 32'hbfaff020, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL wcount_clear: got %h expected 0", data_sram_rdata);
      end
      cycle(1'b1, 32'h0000001c, 32'hcafef00d);
      cycle(1'b0, 32'hbfaff020, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h1) begin
         n_errors++; $display("FAIL wcount_recount: got %h expected 1", data_sram_rdata);
      end
      n_checks++;
      if (led !== 16'habcd) begin
         n_errors++; $display("FAIL ram_write_led_isolation: got %h expected abcd", led);
      end
   endtask

   task automatic test_misaligned();
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++; $display("FAIL err_clean_before_misalign: got %b expected 0", err);
      end
      cycle(1'b0, 32'h1c000012, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'h22) begin
         n_errors++; $display("FAIL misalign_read: got %h expected 22", data_sram_rdata);
      end
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++; $display("FAIL misalign_err: got %b expected 1", err);
      end
   endtask

   task automatic test_reset_mid_op();
      cycle(1'b0, 32'h0000001c, 32'h0);
      @(negedge clk);
      data_sram_we    = 1'b1;
      data_sram_addr  = 32'h0000001c;
      data_sram_wdata = 32'h0bad0bad;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL midrst_rdata: got %h expected 0", data_sram_rdata);
      end
      n_checks++;
      if (led !== 16'h0) begin
         n_errors++; $display("FAIL midrst_led: got %h expected 0", led);
      end
      n_checks++;
      if (timer !== 32'h0) begin
         n_errors++; $display("FAIL midrst_timer: got %h expected 0", timer);
      end
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++; $display("FAIL midrst_err: got %b expected 0", err);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL midrst_rdata_held: got %h expected 0", data_sram_rdata);
      end
      @(negedge clk);
      data_sram_we = 1'b0;
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL postrst_rdata: got %h expected 0", data_sram_rdata);
      end
      cycle(1'b0, 32'h0000001c, 32'h0);
      n_checks++;
      if (data_sram_rdata !== 32'hcafef00d) begin
         n_errors++; $display("FAIL ram_survives_reset: got %h expected cafef00d", data_sram_rdata);
      end
      n_checks++;
      if (timer !== 32'h1) begin
         n_errors++; $display("FAIL postrst_timer: got %h expected 1", timer);
      end
   endtask

   task automatic test_unmapped_error();
      logic [31:0] wc_before;
      cycle(1'b0, 32'hbfaff020, 32'h0);
      wc_before = data_sram_rdata;
      cycle(1'b1, 32'hbfaf0004, 32'h77777777);
      n_checks++;
      if (data_sram_rdata !== 32'h0) begin
         n_errors++; $display("FAIL unmapped_rdata: got %h expected 0", data_sram_rdata);
      end
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++; $display("FAIL unmapped_err: got %b expected 1", err);
      end
      cycle(1'b0, 32'h00000020, 32'h0);
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++; $display("FAIL err_sticky: got %b expected 1", err);
      end
      cycle(1'b0, 32'hbfaff020, 32'h0);
      n_checks++;
      if (data_sram_rdata !== wc_before || data_sram_rdata !== m_wcount) begin
         n_errors++; $display("FAIL unmapped_wcount: got %h expected %h", data_sram_rdata, m_wcount);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      logic        we;
      int unsigned sel;
      for (int i = 0; i < 16; i++) cycle(1'b1, i * 4, $urandom);
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         we  = 1'($urandom_range(0, 1));
         d   = $urandom;
         a   = $urandom;
         if (sel < 6) begin
            a[31:16] = 16'($urandom_range(0, 16'hbfae));
            a[11:2]  = 10'($urandom_range(0, 15));
            a[1:0]   = (sel == 5) ? 2'($urandom_range(0, 3)) : 2'b00;
         end else begin
            a[31:16] = PERI_BASE;
            case (sel)
               6:       a[15:0] = 16'hf000;
               7:       a[15:0] = 16'he000;
               8:       a[15:0] = 16'hf020;
               default: a[15:0] = 16'(4 * $urandom_range(0, 16'h3fff));
            endcase
            if (sel == 7 && $urandom_range(0, 3) != 0) we = 1'b0;
         end
         cycle(we, a, d);
         if (exp_known) begin
            n_checks++;
            if (data_sram_rdata !== exp_rdata) begin
               n_errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, data_sram_rdata, exp_rdata);
            end
         end
         n_checks++;
         if (led !== m_led) begin
            n_errors++; $display("FAIL rand_led[%0d]: got %h expected %h", n, led, m_led);
         end
         n_checks++;
         if (timer !== m_timer) begin
            n_errors++; $display("FAIL rand_timer[%0d]: got %h expected %h", n, timer, m_timer);
         end
         n_checks++;
         if (err !== m_err) begin
            n_errors++; $display("FAIL rand_err[%0d]: got %b expected %b", n, err, m_err);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_write_read();
      test_read_before_write();
      test_timer();
      test_led();
      test_wcount_clear();
      test_misaligned();
      test_reset_mid_op();
      test_unmapped_error();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
